frame_sender: RTL and testbench
===============================

FRAME_SENDER -- requirements
Module: frame_sender

Interface
REQ-001 Parameter DATA_SIZE, default 64, payload bytes per frame.
REQ-002 Parameter PREAMBLE_SIZE, default 7, header bytes per frame.
REQ-003 Parameter CRC_SIZE, default 4, CRC bytes per frame.
REQ-004 Parameter MAX_RETRY, default 3, retransmissions allowed after ERROR or timeout.
REQ-005 Parameter TIMEOUT, default 1024, cycles to wait for a confirmation.
REQ-006 Port clk, input, 1, sole clock, rising edge.
REQ-007 Port rst, input, 1, asynchronous active-high reset.
REQ-008 Port pl_data, input, [0:DATA_SIZE*8-1], payload, byte 0 in bits 0:7.
REQ-009 Port pl_valid, input, 1, payload present.
REQ-010 Port pl_start, input, 1, payload is first of a message.
REQ-011 Port pl_end, input, 1, payload is last of a message.
REQ-012 Port pl_ready, output, 1, payload accepted when pl_valid & pl_ready.
REQ-013 Port Fout, output, [0:FRAME_SIZE], built frame; FRAME_SIZE = (PREAMBLE_SIZE+DATA_SIZE+CRC_SIZE)*8-1.
REQ-014 Port Fout_valid, output, 1, frame offered to the Core.
REQ-015 Port confirm_in, input, 8, confirmation code from the Core.
REQ-016 Port confirm_in_valid, input, 1, confirm_in qualifier.
REQ-017 Port done, output, 1, one-cycle pulse when a payload is finished.
REQ-018 Port status, output, 8, outcome code, valid while done=1.

Function
REQ-019 Frame layout: bits 0:7 type; 8:23 zero; 24:55 frame number; 56 to DATA_SIZE*8+55 payload; last 32 bits CRC.
REQ-020 Type: start&end 0x03 single; start only 0x00 first; end only 0x01 last; neither 0x02 normal.
REQ-021 Frame number: 0 on first/single frames, previous+1 on normal/last frames, 32-bit wrap.
REQ-022 CRC: CRC-32 poly 0x04C11DB7, MSB-first over bits 0 to DATA_SIZE*8+55, register init 0, no reflection, no final XOR; frame with CRC divides to zero remainder.
REQ-023 CRC computed serially one bit per cycle, (PREAMBLE_SIZE+DATA_SIZE)*8 cycles.
REQ-024 States: IDLE, BUILD, CRC, SEND, WAIT_ACK, RETRY, FINISH.
REQ-025 IDLE: pl_ready=1; on accept go BUILD; all others pl_ready=0.
REQ-026 Sequence check in IDLE: pl_start while message open, or !pl_start while none open -> accept, no frame, done=1 status 0x04 next cycle, message state unchanged.
REQ-027 BUILD (1 cycle) assembles header and payload; CRC then runs; SEND sets Fout_valid=1 and goes WAIT_ACK.
REQ-028 Fout stable and Fout_valid held high from SEND until a confirmation or timeout is consumed.
REQ-029 WAIT_ACK, confirm_in_valid with 0x05: Fout_valid=0, FINISH status 0x05; message closes if frame was last/single.
REQ-030 WAIT_ACK, 0x04 or TIMEOUT cycles without confirmation: if retries<MAX_RETRY go RETRY, else FINISH status 0x04 and message closes.
REQ-031 RETRY: Fout_valid=0 for exactly one cycle, retry count +1, then SEND with identical Fout.
REQ-032 WAIT_ACK, 0x08: FINISH status 0x08, message closes, next message numbering restarts at 0.
REQ-033 Other codes with confirm_in_valid ignored; timeout counter keeps running.
REQ-034 FINISH: done=1 one cycle, retry and timeout counters cleared, return IDLE.
REQ-035 confirm_in_valid outside WAIT_ACK ignored.
REQ-036 Latency accept -> Fout_valid = 2 + (PREAMBLE_SIZE+DATA_SIZE)*8 cycles (570 default).

Reset
REQ-037 rst asynchronously forces IDLE, Fout=0, Fout_valid=0, done=0, status=0x00, pl_ready=0 while asserted and 1 the cycle after release, counters 0, no message open, frame number 0.
REQ-038 Reset mid-CRC or mid-WAIT_ACK discards the frame with no done pulse.

Verification
REQ-039 Single payload (start=end=1), confirm 0x05 after 10 cycles -> Fout byte0 0x03, number 0, CRC matches model, Fout_valid 570 cycles after accept, done=1 status 0x05.
REQ-040 Three-payload message, each confirmed 0x05 -> types 0x00,0x02,0x01, numbers 0,1,2.
REQ-041 Confirm 0x04 twice then 0x05 -> three identical Fout offers, Fout_valid low one cycle between, status 0x05.
REQ-042 No confirmation -> offers at 0, +1025, +2050, +3075 cycles, then done status 0x04 after 4th timeout.
REQ-043 0x08 on 2nd frame of a message, then new first payload -> status 0x08, new frame number 0; normal payload with no open message -> status 0x04, no Fout_valid.
REQ-044 rst pulsed during CRC -> Fout_valid stays 0, no done, next accepted payload produces correct frame.

Source files
------------

// File: rtl/frame_sender_if.sv
// frame_sender_if: payload intake, frame offer and confirmation signals of frame_sender
interface frame_sender_if #(
    parameter int DATA_SIZE = 64,
    parameter int PREAMBLE_SIZE = 7,
    parameter int CRC_SIZE = 4
);
    localparam int FRAME_SIZE = (PREAMBLE_SIZE + DATA_SIZE + CRC_SIZE) * 8 - 1;
    logic [0:DATA_SIZE*8-1] pl_data;
    logic pl_valid;
    logic pl_start;
    logic pl_end;
    logic pl_ready;
    logic [0:FRAME_SIZE] Fout;
    logic Fout_valid;
    logic [7:0] confirm_in;
    logic confirm_in_valid;
    logic done;
    logic [7:0] status;
    modport master (
        output pl_data, pl_valid, pl_start, pl_end, confirm_in, confirm_in_valid,
        input pl_ready, Fout, Fout_valid, done, status
    );
    modport slave (
        input pl_data, pl_valid, pl_start, pl_end, confirm_in, confirm_in_valid,
        output pl_ready, Fout, Fout_valid, done, status
    );
endinterface

// File: rtl/frame_sender.sv
// frame_sender: wraps payloads into typed, numbered, CRC-32 protected frames and resends them until confirmed
module frame_sender #(
    parameter int DATA_SIZE = 64,
    parameter int PREAMBLE_SIZE = 7,
    parameter int CRC_SIZE = 4,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT = 1024
) (
    input logic clk,
    input logic rst,
    frame_sender_if.slave bus
);
    localparam int NB = (PREAMBLE_SIZE + DATA_SIZE) * 8;
    localparam int CW = $clog2(NB);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [2:0] IDLE = 3'd0, BUILD = 3'd1, CRC = 3'd2, SEND = 3'd3,
                           WAIT_ACK = 3'd4, RETRY = 3'd5, FINISH = 3'd6;
    localparam logic [7:0] ST_OK = 8'h05, ST_ERR = 8'h04, ST_ABORT = 8'h08;

    logic [2:0] state;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tmr;
    logic [RW-1:0] retry;
    logic [31:0] crc, crc_nxt, fnum, num;
    logic [7:0] typ;
    logic msg_open, last, seq_err, ack, nack, abort, tout, resend;

    always_comb begin
        typ = {6'd0, ~(bus.pl_start ^ bus.pl_end), bus.pl_end};
        num = bus.pl_start ? 32'd0 : fnum + 32'd1;
        seq_err = bus.pl_start == msg_open;
        ack = bus.confirm_in_valid && bus.confirm_in == ST_OK;
        nack = bus.confirm_in_valid && bus.confirm_in == ST_ERR;
        abort = bus.confirm_in_valid && bus.confirm_in == ST_ABORT;
        tout = tmr == TW'(TIMEOUT - 1);
        resend = !ack && !abort && retry < RW'(MAX_RETRY);
        crc_nxt = {crc[30:0], 1'b0} ^ ((crc[31] ^ bus.Fout[cnt]) ? POLY : 32'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            tmr <= '0;
            retry <= '0;
            crc <= '0;
            fnum <= '0;
            msg_open <= 1'b0;
            last <= 1'b0;
            bus.pl_ready <= 1'b0;
            bus.Fout <= '0;
            bus.Fout_valid <= 1'b0;
            bus.done <= 1'b0;
            bus.status <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.pl_valid && bus.pl_ready) begin
                    bus.pl_ready <= 1'b0;
                    // out-of-order payloads are consumed and reported without touching the message
                    if (seq_err) begin
                        bus.done <= 1'b1;
                        bus.status <= ST_ERR;
                        state <= FINISH;
                    end else begin
                        bus.Fout <= {typ, {(PREAMBLE_SIZE*8-40){1'b0}}, num, bus.pl_data,
                                     {(CRC_SIZE*8){1'b0}}};
                        fnum <= num;
                        msg_open <= 1'b1;
                        last <= bus.pl_end;
                        state <= BUILD;
                    end
                end else begin
                    bus.pl_ready <= 1'b1;
                end
                BUILD: begin
                    crc <= '0;
                    cnt <= '0;
                    state <= CRC;
                end
                CRC: begin
                    crc <= crc_nxt;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(NB - 1)) state <= SEND;
                end
                SEND: begin
                    bus.Fout[NB +: 32] <= crc;
                    bus.Fout_valid <= 1'b1;
                    tmr <= '0;
                    state <= WAIT_ACK;
                end
                WAIT_ACK: if (ack || abort || nack || tout) begin
                    bus.Fout_valid <= 1'b0;
                    if (resend) begin
                        state <= RETRY;
                    end else begin
                        bus.done <= 1'b1;
                        bus.status <= ack ? ST_OK : abort ? ST_ABORT : ST_ERR;
                        msg_open <= ack && !last;
                        state <= FINISH;
                    end
                end else begin
                    tmr <= tmr + TW'(1);
                end
                // re-offer directly so the valid gap is a single cycle
                RETRY: begin
                    retry <= retry + RW'(1);
                    tmr <= '0;
                    bus.Fout_valid <= 1'b1;
                    state <= WAIT_ACK;
                end
                FINISH: begin
                    retry <= '0;
                    tmr <= '0;
                    bus.pl_ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_sender.sv
// tb_frame_sender: directed scoreboard bench for frame_sender with default sizes
module tb_frame_sender;
    localparam int D = 64, P = 7, C = 4, FW = (P + D + C) * 8, NB = (P + D) * 8, TO = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0, checks = 0, errors = 0, acc = 0;
    logic [0:FW-1] exp_q[$];
    logic [7:0] st_q[$];

    frame_sender_if #(.DATA_SIZE(D), .PREAMBLE_SIZE(P), .CRC_SIZE(C)) bus();

    frame_sender #(.DATA_SIZE(D), .PREAMBLE_SIZE(P), .CRC_SIZE(C), .MAX_RETRY(3), .TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] crc_of(input logic [0:FW-1] f, input int n);
        logic [31:0] c = 32'd0;
        for (int i = 0; i < n; i++) c = {c[30:0], 1'b0} ^ ((c[31] ^ f[i]) ? 32'h04C11DB7 : 32'd0);
        return c;
    endfunction

    function automatic logic [0:FW-1] mk(input logic [0:D*8-1] d, input logic st, input logic en,
                                         input logic [31:0] num);
        logic [7:0] ty;
        logic [0:FW-1] f;
        ty = (st && en) ? 8'h03 : st ? 8'h00 : en ? 8'h01 : 8'h02;
        f = {ty, 16'h0000, num, d, 32'h0};
        f[NB +: 32] = crc_of(f, NB);
        return f;
    endfunction

    function automatic logic [0:D*8-1] rnd_pl();
        logic [0:D*8-1] d;
        for (int i = 0; i < D / 4; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic frame_eq(input string tag, input logic [0:FW-1] e);
        checks++;
        assert (bus.Fout === e) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, bus.Fout, e);
        end
    endtask

    task automatic chk_frame(input string tag);
        logic [0:FW-1] e;
        e = exp_q.size() != 0 ? exp_q.pop_front() : '0;
        frame_eq(tag, e);
        chk({tag, "_residue"}, crc_of(bus.Fout, FW), 0);
    endtask

    task automatic offer(input logic st, input logic en, input logic [0:D*8-1] d);
        int n = 0;
        while (bus.pl_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("pl_ready", bus.pl_ready, 1);
        bus.pl_data = d;
        bus.pl_start = st;
        bus.pl_end = en;
        bus.pl_valid = 1'b1;
        @(negedge clk);
        bus.pl_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_fv(input string tag, output int t);
        int n = 0;
        while (bus.Fout_valid !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
        t = cyc;
        chk({tag, "_fout_valid"}, bus.Fout_valid, 1);
    endtask

    task automatic wait_low();
        int n = 0;
        while (bus.Fout_valid === 1'b1 && n < 2000) begin @(negedge clk); n++; end
    endtask

    task automatic wait_done(input string tag, output int t);
        int n = 0;
        while (bus.done !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
        t = cyc;
        chk({tag, "_done"}, bus.done, 1);
        chk({tag, "_status"}, bus.status, st_q.size() != 0 ? st_q.pop_front() : 8'hFF);
        @(negedge clk);
        chk({tag, "_done_pulse"}, bus.done, 0);
    endtask

    task automatic confirm(input logic [7:0] code);
        bus.confirm_in = code;
        bus.confirm_in_valid = 1'b1;
        @(negedge clk);
        bus.confirm_in_valid = 1'b0;
    endtask

    task automatic frame_ok(input string tag, input logic st, input logic en, input logic [31:0] num,
                            input logic [7:0] code);
        logic [0:D*8-1] d;
        int t;
        d = rnd_pl();
        exp_q.push_back(mk(d, st, en, num));
        st_q.push_back(code);
        offer(st, en, d);
        wait_fv(tag, t);
        chk_frame({tag, "_frame"});
        confirm(code);
        wait_done(tag, t);
    endtask

    initial begin
        logic [0:D*8-1] d;
        logic [0:FW-1] e;
        int t, prev, seen;
        bus.pl_data = '0;
        bus.pl_valid = 1'b0;
        bus.pl_start = 1'b0;
        bus.pl_end = 1'b0;
        bus.confirm_in = '0;
        bus.confirm_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.pl_ready, 0);
        chk("rst_fv", bus.Fout_valid, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_status", bus.status, 0);
        chk("rst_fout", {63'd0, |bus.Fout}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready_after", bus.pl_ready, 1);

        d = rnd_pl();
        e = mk(d, 1, 1, 0);
        exp_q.push_back(e);
        st_q.push_back(8'h05);
        offer(1, 1, d);
        wait_fv("single", t);
        chk("single_latency", t - acc, 570);
        chk("single_type", bus.Fout[0:7], 8'h03);
        chk_frame("single_frame");
        repeat (10) @(negedge clk);
        chk("single_hold_fv", bus.Fout_valid, 1);
        frame_eq("single_hold_fout", e);
        confirm(8'h05);
        chk("single_fv_drop", bus.Fout_valid, 0);
        wait_done("single", t);

        for (int i = 0; i < 3; i++) frame_ok("msg3", i == 0, i == 2, i, 8'h05);

        d = rnd_pl();
        e = mk(d, 1, 1, 0);
        exp_q.push_back(e);
        st_q.push_back(8'h05);
        offer(1, 1, d);
        wait_fv("nack", t);
        chk_frame("nack_frame0");
        confirm(8'h77);
        chk("nack_other_code", bus.Fout_valid, 1);
        for (int k = 0; k < 2; k++) begin
            confirm(8'h04);
            chk("nack_gap", bus.Fout_valid, 0);
            @(negedge clk);
            chk("nack_reoffer", bus.Fout_valid, 1);
            frame_eq("nack_same", e);
        end
        confirm(8'h05);
        wait_done("nack", t);

        d = rnd_pl();
        e = mk(d, 1, 1, 0);
        exp_q.push_back(e);
        st_q.push_back(8'h04);
        offer(1, 1, d);
        wait_fv("tmo", prev);
        chk_frame("tmo_frame0");
        for (int k = 0; k < 3; k++) begin
            wait_low();
            wait_fv("tmo_retry", t);
            chk("tmo_period", t - prev, TO + 1);
            frame_eq("tmo_same", e);
            prev = t;
        end
        wait_done("tmo", t);
        chk("tmo_final", t - prev, TO);

        frame_ok("abort_first", 1, 0, 0, 8'h05);
        frame_ok("abort_second", 0, 0, 1, 8'h08);
        frame_ok("restart_first", 1, 0, 0, 8'h05);
        st_q.push_back(8'h04);
        offer(1, 0, rnd_pl());
        wait_done("seq_start_open", t);
        frame_ok("restart_last", 0, 1, 1, 8'h05);
        st_q.push_back(8'h04);
        offer(0, 0, rnd_pl());
        chk("seq_none_fv", bus.Fout_valid, 0);
        wait_done("seq_none", t);
        seen = 0;
        repeat (600) begin @(negedge clk); if (bus.Fout_valid) seen = 1; end
        chk("seq_none_no_frame", seen, 0);

        offer(1, 1, rnd_pl());
        repeat (100) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_fv", bus.Fout_valid, 0);
        chk("midrst_ready", bus.pl_ready, 0);
        chk("midrst_fout", {63'd0, |bus.Fout}, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (700) begin @(negedge clk); if (bus.Fout_valid || bus.done) seen = 1; end
        chk("midrst_quiet", seen, 0);
        d = rnd_pl();
        exp_q.push_back(mk(d, 1, 1, 0));
        st_q.push_back(8'h05);
        offer(1, 1, d);
        wait_fv("after_rst", t);
        chk("after_rst_latency", t - acc, 570);
        chk_frame("after_rst_frame");
        confirm(8'h05);
        wait_done("after_rst", t);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
